// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants and state encoding for the iterative divider
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift/compare/subtract iteration
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shifted value can exceed WIDTH bits, so compare one bit wider.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed/unsigned divider with start/ready handshake
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_e state, state_nxt;

  logic [5:0]       cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic             sign1_q, sign2_q;

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic             last_step;
  logic             neg1, neg2;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] q_raw, q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_nxt),
    .q_bit_o   (q_bit)
  );

  // Negating the most negative value wraps to itself, which reads back as the right unsigned magnitude.
  always_comb begin
    neg1      = signed_div_i & opdata1_i[WIDTH-1];
    neg2      = signed_div_i & opdata2_i[WIDTH-1];
    abs1      = neg1 ? -opdata1_i : opdata1_i;
    abs2      = neg2 ? -opdata2_i : opdata2_i;
    last_step = (cnt == 6'(WIDTH-1));
    q_raw     = {dvd_q[WIDTH-2:0], q_bit};
    q_fix     = (sign1_q ^ sign2_q) ? -q_raw : q_raw;
    r_fix     = sign1_q ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE:
        if (start_i == DIV_START && !annul_i)
          state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_nxt = DIV_END;
      DIV_ON:
        if (annul_i)        state_nxt = DIV_IDLE;
        else if (last_step) state_nxt = DIV_END;
      DIV_END:
        if (start_i == DIV_STOP) state_nxt = DIV_IDLE;
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i == DIV_START && !annul_i && opdata2_i != '0) begin
            dvd_q   <= abs1;
            dsr_q   <= abs2;
            rem_q   <= '0;
            sign1_q <= neg1;
            sign2_q <= neg2;
            cnt     <= '0;
          end
        end
        DIV_BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        DIV_ON: begin
          if (annul_i) begin
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            rem_q <= rem_nxt;
            dvd_q <= q_raw;
            cnt   <= cnt + 6'd1;
            if (last_step) begin
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
